// File: rtl/seq_core_read.sv
// Stage-2 decode/read for the sequencer core: resolves jumps and branches, detects
// read-after-write hazards against stage 3, and loads the stage-3 pipeline register.
// Build option: define SEQ_CORE_BRANCH_COND_EN to enable the BRZ/BRNZ conditional branches.
module seq_core_read #(
    parameter int A_SIZE = 10,
    parameter int D_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       ir,
    output logic              r2_pc_halt,
    output logic              r2_pc_load,
    output logic              r2_pc_loadr,
    output logic              r2_pc_flush,
    output logic [A_SIZE-1:0] r2_pc_target,
    output logic [2:0]        rf_addr_a,
    output logic [2:0]        rf_addr_b,
    output logic [2:0]        rf_addr_c,
    input  logic [D_SIZE-1:0] rf_data_a,
    input  logic [D_SIZE-1:0] rf_data_b,
    input  logic [D_SIZE-1:0] rf_data_c,
    input  logic              r3_stall,
    output logic [15:0]       r3_ir,
    output logic [D_SIZE-1:0] r3_data_a,
    output logic [D_SIZE-1:0] r3_data_b
);

    localparam logic [6:0] OP_HALT = 7'b1111111;
    localparam logic [6:0] OP_JMP  = 7'b1000000;
    localparam logic [6:0] OP_JMPR = 7'b1000001;
    localparam logic [6:0] OP_BRZ  = 7'b1001000;
    localparam logic [6:0] OP_BRNZ = 7'b1001001;

    function automatic logic is_writer(input logic [15:0] x);
        return (x[15] == 1'b0) && (x != 16'h0000);
    endfunction

    // The fetch stage has already advanced past the instruction, hence the minus one.
    function automatic logic signed [A_SIZE-1:0] rel_target(input logic [5:0] off);
        logic signed [A_SIZE-1:0] ext;
        ext = A_SIZE'($signed(off));
        return ext - A_SIZE'(1);
    endfunction

    // Stage 2 (p0): decode of the instruction presented by fetch
    logic [6:0] op_p0;
    logic       is_halt_p0, is_jmp_p0, is_jmpr_p0, is_brz_p0, is_brnz_p0;
    logic       bubble_p0;
    logic       r3_writer_p1;
    logic [2:0] r3_dest_p1;
    logic       jmp_hazard_p0, br_hazard_p0, hazard_p0, br_taken_p0;

    assign op_p0      = ir[15:9];
    assign is_halt_p0 = (op_p0 == OP_HALT);
    assign is_jmp_p0  = (op_p0 == OP_JMP);
    assign is_jmpr_p0 = (op_p0 == OP_JMPR);
    assign is_brz_p0  = (op_p0 == OP_BRZ);
    assign is_brnz_p0 = (op_p0 == OP_BRNZ);
    assign bubble_p0  = is_halt_p0 | is_jmp_p0 | is_jmpr_p0 | is_brz_p0 | is_brnz_p0;

    assign rf_addr_a = ir[5:3];
    assign rf_addr_b = ir[2:0];
    assign rf_addr_c = ir[8:6];

    assign r3_writer_p1  = is_writer(r3_ir);
    assign r3_dest_p1    = r3_ir[8:6];
    assign jmp_hazard_p0 = is_jmp_p0 && r3_writer_p1 && (r3_dest_p1 == ir[2:0]);

`ifdef SEQ_CORE_BRANCH_COND_EN
    assign br_taken_p0  = (is_brz_p0 && (rf_data_c == '0)) || (is_brnz_p0 && (rf_data_c != '0));
    assign br_hazard_p0 = (is_brz_p0 || is_brnz_p0) && r3_writer_p1 && (r3_dest_p1 == ir[8:6]);
`else
    logic unused_data_c;
    assign unused_data_c = ^rf_data_c;
    assign br_taken_p0   = 1'b0;
    assign br_hazard_p0  = 1'b0;
`endif

    assign hazard_p0 = jmp_hazard_p0 | br_hazard_p0;

    always_comb begin
        r2_pc_halt   = 1'b0;
        r2_pc_load   = 1'b0;
        r2_pc_loadr  = 1'b0;
        r2_pc_flush  = 1'b0;
        r2_pc_target = '0;
        if (r3_stall || is_halt_p0 || hazard_p0) begin
            r2_pc_halt = 1'b1;
        end else if (is_jmp_p0) begin
            r2_pc_load   = 1'b1;
            r2_pc_flush  = 1'b1;
            r2_pc_target = rf_data_b[A_SIZE-1:0];
        end else if (is_jmpr_p0 || br_taken_p0) begin
            r2_pc_loadr  = 1'b1;
            r2_pc_flush  = 1'b1;
            r2_pc_target = rel_target(ir[5:0]);
        end
    end

    // Stage 3 (p1): pipeline register, held under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_ir     <= '0;
            r3_data_a <= '0;
            r3_data_b <= '0;
        end else if (!r3_stall) begin
            if (bubble_p0) begin
                r3_ir     <= '0;
                r3_data_a <= '0;
                r3_data_b <= '0;
            end else begin
                r3_ir     <= ir;
                r3_data_a <= rf_data_a;
                r3_data_b <= rf_data_b;
            end
        end
    end

endmodule

// File: tb/tb_seq_core_read.sv
// Self-checking bench for seq_core_read: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_seq_core_read;

    localparam int A_SIZE = 10;
    localparam int D_SIZE = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       ir = '0;
    logic              r2_pc_halt, r2_pc_load, r2_pc_loadr, r2_pc_flush;
    logic [A_SIZE-1:0] r2_pc_target;
    logic [2:0]        rf_addr_a, rf_addr_b, rf_addr_c;
    logic [D_SIZE-1:0] rf_data_a = '0, rf_data_b = '0, rf_data_c = '0;
    logic              r3_stall = 1'b0;
    logic [15:0]       r3_ir;
    logic [D_SIZE-1:0] r3_data_a, r3_data_b;

    seq_core_read #(.A_SIZE(A_SIZE), .D_SIZE(D_SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir),
        .r2_pc_halt(r2_pc_halt), .r2_pc_load(r2_pc_load), .r2_pc_loadr(r2_pc_loadr),
        .r2_pc_flush(r2_pc_flush), .r2_pc_target(r2_pc_target),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_addr_c(rf_addr_c),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .rf_data_c(rf_data_c),
        .r3_stall(r3_stall), .r3_ir(r3_ir), .r3_data_a(r3_data_a), .r3_data_b(r3_data_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state: contents of the stage-3 register
    logic [15:0] m_ir = '0;
    logic [31:0] m_a = '0, m_b = '0;

    // outputs sampled during the last step, for directed constant checks
    logic       s_halt, s_load, s_loadr, s_flush;
    logic [9:0] s_tgt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit writes_reg(input logic [15:0] x);
        return x[15] == 1'b0 && x != 16'h0;
    endfunction

    // One clock cycle: present inputs, check fetch controls, then check the stage-3 register.
    task automatic step(input logic [15:0] i, input logic s,
                        input logic [31:0] da, input logic [31:0] db, input logic [31:0] dc);
        bit e_halt, e_load, e_loadr, e_flush, e_clear;
        int e_tgt;
        int rel;
        @(negedge clk);
        ir = i; r3_stall = s; rf_data_a = da; rf_data_b = db; rf_data_c = dc;
        #1;
        e_halt = 0; e_load = 0; e_loadr = 0; e_flush = 0; e_tgt = 0; e_clear = 0;
        rel = (int'($signed(i[5:0])) - 1) & 32'h3FF;
        case (i[15:9])
            7'h7F: begin e_halt = 1; e_clear = 1; end
            7'h40: begin
                e_clear = 1;
                if (writes_reg(m_ir) && m_ir[8:6] == i[2:0]) e_halt = 1;
                else begin e_load = 1; e_flush = 1; e_tgt = int'(db) & 32'h3FF; end
            end
            7'h41: begin e_clear = 1; e_loadr = 1; e_flush = 1; e_tgt = rel; end
            7'h48, 7'h49: begin
                e_clear = 1;
`ifdef SEQ_CORE_BRANCH_COND_EN
                if (writes_reg(m_ir) && m_ir[8:6] == i[8:6]) e_halt = 1;
                else if ((dc == 0) == (i[15:9] == 7'h48)) begin
                    e_loadr = 1; e_flush = 1; e_tgt = rel;
                end
`endif
            end
            default: e_clear = 0;
        endcase
        if (s) begin e_halt = 1; e_load = 0; e_loadr = 0; e_flush = 0; e_tgt = 0; end
        s_halt = r2_pc_halt; s_load = r2_pc_load; s_loadr = r2_pc_loadr;
        s_flush = r2_pc_flush; s_tgt = r2_pc_target;
        check("halt", 32'(r2_pc_halt), 32'(e_halt));
        check("load", 32'(r2_pc_load), 32'(e_load));
        check("loadr", 32'(r2_pc_loadr), 32'(e_loadr));
        check("flush", 32'(r2_pc_flush), 32'(e_flush));
        check("target", 32'(r2_pc_target), e_tgt);
        check("rf_addr", {23'h0, rf_addr_c, rf_addr_b, rf_addr_a}, {23'h0, i[8:6], i[2:0], i[5:3]});
        @(posedge clk);
        if (!s) begin
            if (e_clear) begin m_ir = '0; m_a = '0; m_b = '0; end
            else begin m_ir = i; m_a = da; m_b = db; end
        end
        #1;
        check("r3_ir", 32'(r3_ir), 32'(m_ir));
        check("r3_data_a", r3_data_a, m_a);
        check("r3_data_b", r3_data_b, m_b);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_r3_ir", 32'(r3_ir), 0);
        check("rst_r3_a", r3_data_a, 0);
        check("rst_r3_b", r3_data_b, 0);
        m_ir = '0; m_a = '0; m_b = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] ri;
        // reset state, with ir = 0
        #2;
        check("init_r3_ir", 32'(r3_ir), 0);
        check("init_pc", {28'h0, r2_pc_halt, r2_pc_load, r2_pc_loadr, r2_pc_flush}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h0000, 1'b0, 32'h1, 32'h2, 32'h3);

        // asynchronous reset with a loaded stage-3 register
        step(16'h1234, 1'b0, 32'hAAAA_5555, 32'hBBBB_0001, 32'h0);
        check("loaded_r3_ir", 32'(r3_ir), 32'h1234);
        reset_pulse();

        // JMPR -3
        step(16'h823D, 1'b0, 32'h0, 32'h0, 32'h0);
        check("jmpr_loadr", 32'(s_loadr), 1);
        check("jmpr_target", 32'(s_tgt), 32'h3FC);
        check("jmpr_flush", 32'(s_flush), 1);
        check("jmpr_r3_ir", 32'(r3_ir), 0);

        // BRZ R2, +5 taken and not taken
        step(16'h9085, 1'b0, 32'h0, 32'h0, 32'h0);
`ifdef SEQ_CORE_BRANCH_COND_EN
        check("brz_taken_loadr", 32'(s_loadr), 1);
        check("brz_taken_target", 32'(s_tgt), 32'h004);
`else
        check("brz_disabled_loadr", 32'(s_loadr), 0);
`endif
        step(16'h9085, 1'b0, 32'h0, 32'h0, 32'h7);
        check("brz_nt_loadr", 32'(s_loadr), 0);
        check("brz_nt_r3_ir", 32'(r3_ir), 0);

        // JMP R2 right behind a writer of R2
        step(16'h0283, 1'b0, 32'h11, 32'h22, 32'h0);
        step(16'h8002, 1'b0, 32'h0, 32'h155, 32'h0);
        check("haz_halt", 32'(s_halt), 1);
        check("haz_load", 32'(s_load), 0);
        check("haz_r3_ir", 32'(r3_ir), 0);
        step(16'h8002, 1'b0, 32'h0, 32'h155, 32'h0);
        check("jmp_load", 32'(s_load), 1);
        check("jmp_target", 32'(s_tgt), 32'h155);
        check("jmp_flush", 32'(s_flush), 1);

        // HALT held, then reset pulse
        for (int k = 0; k < 5; k++) begin
            step(16'hFE00, 1'b0, 32'h5, 32'h6, 32'h0);
            check("halt_held", 32'(s_halt), 1);
            check("halt_r3_ir", 32'(r3_ir), 0);
        end
        reset_pulse();
        step(16'h0000, 1'b0, 32'h0, 32'h0, 32'h0);
        check("post_rst_pc", {27'h0, s_halt, s_load, s_loadr, s_flush, 1'b0}, 0);
        check("post_rst_tgt", 32'(s_tgt), 0);

        // JMPR under backpressure
        step(16'h0283, 1'b0, 32'hCAFE, 32'hBEEF, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step(16'h823D, 1'b1, 32'h0, 32'h0, 32'h0);
            check("stall_halt", 32'(s_halt), 1);
            check("stall_loadr", 32'(s_loadr), 0);
            check("stall_held_ir", 32'(r3_ir), 32'h0283);
            check("stall_held_a", r3_data_a, 32'hCAFE);
        end
        step(16'h823D, 1'b0, 32'h0, 32'h0, 32'h0);
        check("unstall_loadr", 32'(s_loadr), 1);
        check("unstall_flush", 32'(s_flush), 1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: ri = 16'h0000;
                1: ri = {7'h7F, 9'($urandom)};
                2: ri = {7'h40, 9'($urandom)};
                3: ri = {7'h41, 9'($urandom)};
                4: ri = {7'h48, 9'($urandom)};
                5: ri = {7'h49, 9'($urandom)};
                6, 7: ri = {1'b0, 15'($urandom)};
                default: ri = {1'b1, 15'($urandom)};
            endcase
            step(ri, ($urandom_range(0, 5) == 0),
                 $urandom, $urandom, ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom);
            if (n == 200) reset_pulse();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_core_read.md
SEQ_CORE_READ -- requirements
Module: seq_core_read

Interface
REQ-001 SHALL have parameter A_SIZE, default 10, program-address width.
REQ-002 SHALL have parameter D_SIZE, default 32, register-data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ir  input  16  instruction register from the fetch stage.
REQ-006 SHALL have ports r2_pc_halt, r2_pc_load, r2_pc_loadr, r2_pc_flush  output  1 each  fetch-stage controls, driven combinationally.
REQ-007 SHALL have port r2_pc_target  output  A_SIZE  absolute target for load, or signed addend for loadr.
REQ-008 SHALL have ports rf_addr_a, rf_addr_b, rf_addr_c  output  3 each  register-file read addresses: ir[5:3], ir[2:0] and ir[8:6], combinational.
REQ-009 SHALL have ports rf_data_a, rf_data_b, rf_data_c  input  D_SIZE each  same-cycle read data.
REQ-010 SHALL have port r3_stall  input  1  stage-3 backpressure.
REQ-011 SHALL have ports r3_ir (16), r3_data_a, r3_data_b (D_SIZE)  output  registered stage-3 pipeline register.

Function
REQ-012 SHALL decode opcode ir[15:9]: NOP = ir all zero; HALT = 7'b1111111; JMP = 7'b1000000; JMPR = 7'b1000001; BRZ = 7'b1001000; BRNZ = 7'b1001001.
REQ-013 SHALL treat any opcode with bit 6 = 0 and ir != 0 as a writer whose destination is ir[8:6].
REQ-014 JMP SHALL be taken unconditionally: r2_pc_load = 1, r2_pc_target = rf_data_b[A_SIZE-1:0].
REQ-015 JMPR SHALL be taken unconditionally: r2_pc_loadr = 1, r2_pc_target = sign-extended ir[5:0] minus 1, so the destination is the instruction address plus the offset; arithmetic wraps modulo 2^A_SIZE.
REQ-016 BRZ/BRNZ SHALL be taken when rf_data_c == 0 (or != 0), with target computed as for JMPR.
REQ-017 SHALL apply this priority each cycle: r3_stall > HALT > hazard > taken jump > pass.
REQ-018 r3_stall = 1 SHALL give r2_pc_halt = 1, load/loadr/flush = 0, and hold all r3_* registers.
REQ-019 HALT SHALL give r2_pc_halt = 1 and r3_* <= 0; the condition persists while the fetch stage holds ir.
REQ-020 Hazard SHALL be detected when ir is JMP (reads ir[2:0]) or BRZ/BRNZ (reads ir[8:6]) and r3_ir is a writer with the same destination.
REQ-021 On a hazard the block SHALL drive r2_pc_halt = 1, no load/flush, and r3_* <= 0, a one-cycle bubble.
REQ-022 A taken jump SHALL assert r2_pc_flush = 1 with load or loadr for exactly one cycle and set r3_* <= 0.
REQ-023 A not-taken branch SHALL produce no pc action and set r3_* <= 0.
REQ-024 Pass SHALL register r3_ir <= ir, r3_data_a <= rf_data_a and r3_data_b <= rf_data_b.
REQ-025 r2_pc_load and r2_pc_loadr SHALL never both be 1; r2_pc_target SHALL be 0 when neither is 1.
REQ-026 r2_pc_flush SHALL never be 1 while r2_pc_halt is 1.

Reset
REQ-027 rst_n = 0 SHALL immediately clear r3_ir, r3_data_a and r3_data_b to 0, including mid-halt or mid-hazard.
REQ-028 With ir = 0 after reset, all r2_pc_* outputs SHALL be 0.

Configuration
REQ-029 With macro SEQ_CORE_BRANCH_COND_EN defined, BRZ/BRNZ SHALL be decoded as in REQ-016/020.
REQ-030 With SEQ_CORE_BRANCH_COND_EN undefined, BRZ/BRNZ SHALL cause no pc action and no hazard check, and r3_* <= 0.

Verification (A_SIZE = 10, D_SIZE = 32)
REQ-031 Assert rst_n = 0 with r3_* nonzero -> r3_ir = r3_data_a = r3_data_b = 0 asynchronously.
REQ-032 ir = 16'h823D (JMPR -3) -> r2_pc_loadr = 1, r2_pc_target = 10'h3FC, r2_pc_flush = 1; next cycle r3_ir = 0.
REQ-033 ir = 16'h9085 (BRZ R2, +5), rf_data_c = 0 -> loadr = 1, target = 10'h004; rf_data_c = 7 -> no pc action, r3_ir = 0.
REQ-034 r3_ir = 16'h0283 (writer to R2), ir = 16'h8002 (JMP R2), rf_data_b = 32'h155 -> cycle 1: halt = 1, r3_ir <= 0; cycle 2: load = 1, target = 10'h155, flush = 1.
REQ-035 ir = 16'hFE00 held for 5 cycles -> r2_pc_halt = 1 every cycle, r3_ir = 0; then rst_n pulse -> all outputs 0.
REQ-036 ir = 16'h823D with r3_stall = 1 for 2 cycles -> halt = 1, no loadr, r3_* held; r3_stall = 0 -> loadr = 1 and flush = 1 in that cycle.
